// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared state encodings, opcodes, ALUop codes and control vector
package cpu_ctrl_pkg;
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_RTYPE_EX, S_RTYPE_WB, S_BEQ_EX, S_JUMP, S_ADDI_EX, S_ADDI_WB
  } state_t;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  typedef struct packed {
    logic [1:0] alu_op;
    logic       addi;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       i_or_d;
    logic       reg_dst;
    logic       mem_to_reg;
    logic [1:0] pc_source;
    logic       pc_write;
    logic       pc_write_cond;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
  } ctrl_t;
endpackage

// File: rtl/main_control_decode.sv
// main_control_decode: maps the current state to the datapath control vector
module main_control_decode
  import cpu_ctrl_pkg::*;
(
  input  state_t i_state,
  input  logic   i_mem_ready,
  output ctrl_t  o_ctrl
);
  // per-state control decode; unlisted fields stay 0
  always_comb begin
    o_ctrl = '0;
    case (i_state)
      S_FETCH: begin
        o_ctrl.mem_read  = 1'b1;
        o_ctrl.alu_src_b = 2'b01;
        o_ctrl.alu_op    = ALU_ADD;
        o_ctrl.ir_write  = i_mem_ready;
        o_ctrl.pc_write  = i_mem_ready;
      end
      S_DECODE: begin
        o_ctrl.alu_src_b = 2'b11;
        o_ctrl.alu_op    = ALU_ADD;
      end
      S_MEMADR: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = 2'b10;
        o_ctrl.alu_op    = ALU_ADD;
      end
      S_MEMRD: begin
        o_ctrl.mem_read = 1'b1;
        o_ctrl.i_or_d   = 1'b1;
      end
      S_MEMWR: begin
        o_ctrl.mem_write = 1'b1;
        o_ctrl.i_or_d    = 1'b1;
      end
      S_MEMWB: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.mem_to_reg = 1'b1;
      end
      S_RTYPE_EX: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_op    = ALU_FUNCT;
      end
      S_RTYPE_WB: begin
        o_ctrl.reg_write = 1'b1;
        o_ctrl.reg_dst   = 1'b1;
      end
      S_BEQ_EX: begin
        o_ctrl.alu_src_a     = 1'b1;
        o_ctrl.alu_op        = ALU_SUB;
        o_ctrl.pc_write_cond = 1'b1;
        o_ctrl.pc_source     = 2'b01;
      end
      S_JUMP: begin
        o_ctrl.pc_write  = 1'b1;
        o_ctrl.pc_source = 2'b10;
      end
      S_ADDI_EX: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = 2'b10;
        o_ctrl.alu_op    = ALU_FUNCT;
        o_ctrl.addi      = 1'b1;
      end
      S_ADDI_WB: o_ctrl.reg_write = 1'b1;
      default: o_ctrl = '0;
    endcase
  end
endmodule

// File: rtl/main_control_fsm.sv
// main_control_fsm: multi-cycle CPU main controller with memory wait handshake
module main_control_fsm
  import cpu_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic [1:0] ALUop,
  output logic       addi,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       IorD,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic [1:0] PCSource,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       illegal_op,
  output logic [3:0] state
);
  state_t r_state;
  ctrl_t  w_ctrl;
  logic   w_legal;
  assign w_legal = opcode inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};
  main_control_decode u_decode (
    .i_state    (r_state),
    .i_mem_ready(mem_ready),
    .o_ctrl     (w_ctrl)
  );
  // state register; reset wins over every transition, including memory waits
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else case (r_state)
      S_FETCH:    if (mem_ready) r_state <= S_DECODE;
      S_DECODE:   r_state <= (opcode == OP_LW || opcode == OP_SW) ? S_MEMADR :
                             (opcode == OP_R)    ? S_RTYPE_EX :
                             (opcode == OP_BEQ)  ? S_BEQ_EX :
                             (opcode == OP_J)    ? S_JUMP :
                             (opcode == OP_ADDI) ? S_ADDI_EX : S_FETCH;
      S_MEMADR:   r_state <= (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:    if (mem_ready) r_state <= S_MEMWB;
      S_MEMWR:    if (mem_ready) r_state <= S_FETCH;
      S_RTYPE_EX: r_state <= S_RTYPE_WB;
      S_ADDI_EX:  r_state <= S_ADDI_WB;
      default:    r_state <= S_FETCH;
    endcase
  end
  assign {ALUop, addi, ALUSrcA, ALUSrcB, IorD, RegDst, MemtoReg, PCSource,
          PCWrite, PCWriteCond, MemRead, MemWrite, IRWrite, RegWrite} = reset ? '0 : w_ctrl;
  assign illegal_op = !reset && r_state == S_DECODE && !w_legal;
  assign state = r_state;
endmodule

// File: tb/tb_main_control_fsm.sv
// tb_main_control_fsm: randomized instruction-level check of the main controller
module tb_main_control_fsm;
  import cpu_ctrl_pkg::*;
  logic clk = 1'b0, reset = 1'b1, mem_ready = 1'b1;
  logic [5:0] opcode = '0;
  logic [1:0] ALUop, ALUSrcB, PCSource;
  logic addi, ALUSrcA, IorD, RegDst, MemtoReg, PCWrite, PCWriteCond;
  logic MemRead, MemWrite, IRWrite, RegWrite, illegal_op;
  logic [3:0] state;
  logic [17:0] w_vec;
  int n_tests = 0, n_fail = 0, n_cyc = 0;
  logic [5:0] cur_op;
  main_control_fsm dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .ALUop(ALUop), .addi(addi), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .IorD(IorD), .RegDst(RegDst), .MemtoReg(MemtoReg), .PCSource(PCSource),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .illegal_op(illegal_op), .state(state)
  );
  assign w_vec = {ALUop, addi, ALUSrcA, ALUSrcB, IorD, RegDst, MemtoReg, PCSource,
                  PCWrite, PCWriteCond, MemRead, MemWrite, IRWrite, RegWrite, illegal_op};
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  // expected control vector for one cycle, written from the per-state tables
  function automatic logic [17:0] exp_vec(input state_t s, input logic mr, input logic ill);
    logic [1:0] aluop = 2'b00, srcb = 2'b00, pcs = 2'b00;
    logic ad = 0, srca = 0, iord = 0, rd = 0, m2r = 0, pcw = 0, pcwc = 0;
    logic mrd = 0, mw = 0, irw = 0, rw = 0;
    if (s == S_FETCH) begin mrd = 1; srcb = 2'b01; irw = mr; pcw = mr; end
    if (s == S_DECODE) srcb = 2'b11;
    if (s == S_MEMADR) begin srca = 1; srcb = 2'b10; end
    if (s == S_MEMRD) begin mrd = 1; iord = 1; end
    if (s == S_MEMWR) begin mw = 1; iord = 1; end
    if (s == S_MEMWB) begin rw = 1; m2r = 1; end
    if (s == S_RTYPE_EX) begin srca = 1; aluop = 2'b10; end
    if (s == S_RTYPE_WB) begin rw = 1; rd = 1; end
    if (s == S_BEQ_EX) begin srca = 1; aluop = 2'b01; pcwc = 1; pcs = 2'b01; end
    if (s == S_JUMP) begin pcw = 1; pcs = 2'b10; end
    if (s == S_ADDI_EX) begin srca = 1; srcb = 2'b10; aluop = 2'b10; ad = 1; end
    if (s == S_ADDI_WB) rw = 1;
    return {aluop, ad, srca, srcb, iord, rd, m2r, pcs, pcw, pcwc, mrd, mw, irw, rw, ill};
  endfunction
  function automatic int cpi(input logic [5:0] op);
    return (op == OP_LW) ? 5 : (op == OP_BEQ || op == OP_J) ? 3 : 4;
  endfunction
  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction
  // one clock of an instruction: opcode is garbage outside the states that sample it
  task automatic step(input state_t s, input logic mr, input logic ill);
    mem_ready = mr;
    opcode = (s == S_DECODE || s == S_MEMADR) ? cur_op : 6'($urandom);
    #4;
    chk({"state_", s.name()}, 32'(state), 32'(s));
    chk({"outs_", s.name()}, 32'(w_vec), 32'(exp_vec(s, mr, ill)));
    n_cyc++;
    @(posedge clk);
    #1;
  endtask
  task automatic run_instr(input logic [5:0] op, input int fw, input int mw);
    logic legal;
    legal = op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};
    cur_op = op;
    n_cyc = 0;
    repeat (fw) step(S_FETCH, 0, 0);
    step(S_FETCH, 1, 0);
    step(S_DECODE, rb(), !legal);
    if (!legal) return;
    if (op == OP_LW || op == OP_SW) step(S_MEMADR, rb(), 0);
    if (op == OP_LW) begin
      repeat (mw) step(S_MEMRD, 0, 0);
      step(S_MEMRD, 1, 0);
      step(S_MEMWB, rb(), 0);
    end
    if (op == OP_SW) begin
      repeat (mw) step(S_MEMWR, 0, 0);
      step(S_MEMWR, 1, 0);
    end
    if (op == OP_R) begin step(S_RTYPE_EX, rb(), 0); step(S_RTYPE_WB, rb(), 0); end
    if (op == OP_BEQ) step(S_BEQ_EX, rb(), 0);
    if (op == OP_J) step(S_JUMP, rb(), 0);
    if (op == OP_ADDI) begin step(S_ADDI_EX, rb(), 0); step(S_ADDI_WB, rb(), 0); end
    if (fw == 0 && mw == 0) chk("cpi", 32'(n_cyc), 32'(cpi(op)));
  endtask
  initial begin
    logic [5:0] ops [6];
    ops = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};
    reset = 1'b1;
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_outs0", 32'(w_vec), 32'd0);
    @(posedge clk);
    #1;
    chk("rst_state", 32'(state), 32'(S_FETCH));
    chk("rst_outs1", 32'(w_vec), 32'd0);
    reset = 1'b0;
    run_instr(OP_LW, 0, 0);
    run_instr(OP_ADDI, 0, 0);
    run_instr(OP_SW, 0, 3);
    run_instr(6'b111111, 0, 0);
    run_instr(OP_R, 1, 0);
    run_instr(OP_BEQ, 0, 0);
    run_instr(OP_J, 2, 0);
    run_instr(OP_SW, 0, 0);
    cur_op = OP_LW;
    step(S_FETCH, 1, 0);
    step(S_DECODE, 1, 0);
    step(S_MEMADR, 1, 0);
    step(S_MEMRD, 0, 0);
    step(S_MEMRD, 0, 0);
    reset = 1'b1;
    mem_ready = 1'b1;
    #4;
    chk("rst_midwait_outs", 32'(w_vec), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    run_instr(OP_LW, 0, 0);
    for (int i = 0; i < 300; i++) begin
      logic [5:0] op;
      op = ($urandom_range(0, 7) == 0) ? 6'($urandom) : ops[$urandom_range(0, 5)];
      run_instr(op, $urandom_range(0, 2), $urandom_range(0, 2));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
